rv64g_l1_refill_engine: RTL and testbench

- Sits directly downstream of the L1 VLSU miss handler.
- Takes one line-refill request at a time and issues a TileLink AcquireBlock on channel A.
- Collects the GrantData beats on channel D and writes the assembled line, tag and permission into the L1 data/tag arrays.
- Sends GrantAck on channel E, then pulses refill_done back to the miss handler.

---
 rtl/rv64g_l1_refill_engine.sv | 194 +++++++++++++++++++
 tb/tb_rv64g_l1_refill_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv64g_l1_refill_engine.sv
// L1 line-refill engine: one TileLink AcquireBlock, GrantData collection, array write, GrantAck, done pulse.
// Optional macro REFILL_DENIED_RETRY_EN re-issues a denied Acquire up to MAX_RETRY times.
module rv64g_l1_refill_engine #(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int BEAT_W     = 64,
    parameter int INDEX_W    = 5,
    parameter int TAG_W      = 53,
    parameter int SOURCE_W   = 4,
    parameter int SOURCE_ID  = 0,
    parameter int SINK_W     = 4,
    parameter int MAX_RETRY  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    refill_req_i,
    input  logic [ADDR_W-1:0]       refill_addr_i,
    output logic                    refill_done_o,
    output logic                    refill_err_o,
    output logic                    busy_o,
    output logic                    a_valid_o,
    input  logic                    a_ready_i,
    output logic [2:0]              a_opcode_o,
    output logic [2:0]              a_param_o,
    output logic [3:0]              a_size_o,
    output logic [SOURCE_W-1:0]     a_source_o,
    output logic [ADDR_W-1:0]       a_address_o,
    input  logic                    d_valid_i,
    output logic                    d_ready_o,
    input  logic [2:0]              d_opcode_i,
    input  logic [1:0]              d_param_i,
    input  logic [SINK_W-1:0]       d_sink_i,
    input  logic                    d_denied_i,
    input  logic                    d_corrupt_i,
    input  logic [BEAT_W-1:0]       d_data_i,
    output logic                    e_valid_o,
    input  logic                    e_ready_i,
    output logic [SINK_W-1:0]       e_sink_o,
    output logic                    line_we_o,
    output logic [INDEX_W-1:0]      line_index_o,
    output logic [TAG_W-1:0]        line_tag_o,
    output logic [1:0]              line_perm_o,
    output logic [LINE_BYTES*8-1:0] line_data_o
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int BEATS = LINE_BYTES * 8 / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (BEATS * BEAT_W != LINE_BYTES * 8 || TAG_W != ADDR_W - INDEX_W - OFF_W || MAX_RETRY < 0) begin : g_bad_cfg
        $error("rv64g_l1_refill_engine: inconsistent line/tag/retry parameters");
    end

    typedef enum logic [2:0] {S_IDLE, S_ACQ, S_BEATS, S_WRITE, S_ACK, S_DONE} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [CNT_W-1:0]    beat_cnt_reg;
    logic                denied_reg;
    logic                error_reg;
    logic [SINK_W-1:0]   sink_reg;
    logic [1:0]          perm_reg;
    logic [BEAT_W-1:0]   beat_mem [BEATS];
    logic                a_valid_reg, d_ready_reg, e_valid_reg;
    logic                line_we_reg, done_reg, err_reg, busy_reg;
`ifdef REFILL_DENIED_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0]  retry_cnt_reg;
`endif

    // Flag values including the beat being accepted this cycle.
    logic denied_next, error_next, last_beat;
    assign denied_next = denied_reg | d_denied_i;
    assign error_next  = error_reg | d_corrupt_i | (d_opcode_i != 3'd5);
    assign last_beat   = (beat_cnt_reg == CNT_W'(BEATS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            beat_cnt_reg <= '0;
            denied_reg   <= 1'b0;
            error_reg    <= 1'b0;
            sink_reg     <= '0;
            perm_reg     <= 2'b00;
            for (int i = 0; i < BEATS; i++) beat_mem[i] <= '0;
            a_valid_reg  <= 1'b0;
            d_ready_reg  <= 1'b0;
            e_valid_reg  <= 1'b0;
            line_we_reg  <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
`ifdef REFILL_DENIED_RETRY_EN
            retry_cnt_reg <= '0;
`endif
        end else begin
            line_we_reg <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            case (state_reg)
                S_IDLE: if (refill_req_i) begin
                    addr_reg     <= refill_addr_i & ~ADDR_W'(LINE_BYTES - 1);
                    beat_cnt_reg <= '0;
                    denied_reg   <= 1'b0;
                    error_reg    <= 1'b0;
                    busy_reg     <= 1'b1;
                    a_valid_reg  <= 1'b1;
`ifdef REFILL_DENIED_RETRY_EN
                    retry_cnt_reg <= '0;
`endif
                    state_reg    <= S_ACQ;
                end
                S_ACQ: if (a_ready_i) begin
                    a_valid_reg <= 1'b0;
                    d_ready_reg <= 1'b1;
                    state_reg   <= S_BEATS;
                end
                S_BEATS: if (d_valid_i) begin
                    beat_mem[beat_cnt_reg] <= d_data_i;
                    if (beat_cnt_reg == '0) begin
                        sink_reg <= d_sink_i;
                        perm_reg <= (d_param_i == 2'd0) ? 2'b10 : 2'b01;
                    end
                    denied_reg <= denied_next;
                    error_reg  <= error_next;
                    if (d_opcode_i == 3'd4) begin
                        // Dataless Grant: nothing to write, acknowledge straight away.
                        beat_cnt_reg <= '0;
                        d_ready_reg  <= 1'b0;
                        e_valid_reg  <= 1'b1;
                        state_reg    <= S_ACK;
                    end else if (last_beat) begin
                        beat_cnt_reg <= '0;
                        d_ready_reg  <= 1'b0;
                        line_we_reg  <= !denied_next && !error_next;
                        state_reg    <= S_WRITE;
                    end else begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                end
                S_WRITE: begin
                    e_valid_reg <= 1'b1;
                    state_reg   <= S_ACK;
                end
                S_ACK: if (e_ready_i) begin
                    e_valid_reg <= 1'b0;
`ifdef REFILL_DENIED_RETRY_EN
                    if (denied_reg && !error_reg && retry_cnt_reg < RETRY_W'(MAX_RETRY)) begin
                        retry_cnt_reg <= retry_cnt_reg + 1'b1;
                        denied_reg    <= 1'b0;
                        a_valid_reg   <= 1'b1;
                        state_reg     <= S_ACQ;
                    end else begin
                        done_reg  <= 1'b1;
                        err_reg   <= denied_reg | error_reg;
                        state_reg <= S_DONE;
                    end
`else
                    done_reg  <= 1'b1;
                    err_reg   <= denied_reg | error_reg;
                    state_reg <= S_DONE;
`endif
                end
                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
        assign line_data_o[gi*BEAT_W +: BEAT_W] = beat_mem[gi];
    end

    // Fixed A fields read as zero whenever no Acquire is outstanding.
    assign a_opcode_o    = a_valid_reg ? 3'd6 : 3'd0;
    assign a_param_o     = 3'd0;
    assign a_size_o      = a_valid_reg ? 4'(OFF_W) : 4'd0;
    assign a_source_o    = a_valid_reg ? SOURCE_W'(SOURCE_ID) : '0;
    assign a_address_o   = addr_reg;
    assign a_valid_o     = a_valid_reg;
    assign d_ready_o     = d_ready_reg;
    assign e_valid_o     = e_valid_reg;
    assign e_sink_o      = sink_reg;
    assign line_we_o     = line_we_reg;
    assign line_index_o  = addr_reg[OFF_W +: INDEX_W];
    assign line_tag_o    = addr_reg[ADDR_W-1 -: TAG_W];
    assign line_perm_o   = perm_reg;
    assign refill_done_o = done_reg;
    assign refill_err_o  = err_reg;
    assign busy_o        = busy_reg;
endmodule

// File: tb/tb_rv64g_l1_refill_engine.sv
// Directed bench for rv64g_l1_refill_engine with a write/done scoreboard and cycle-level channel responders.
module tb_rv64g_l1_refill_engine;
    localparam int BEATS = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         refill_req = 1'b0;
    logic [63:0]  refill_addr = '0;
    logic         refill_done, refill_err, busy;
    logic         a_valid, a_ready = 1'b0;
    logic [2:0]   a_opcode, a_param;
    logic [3:0]   a_size, a_source;
    logic [63:0]  a_address;
    logic         d_valid = 1'b0, d_ready;
    logic [2:0]   d_opcode = 3'd5;
    logic [1:0]   d_param = 2'd0;
    logic [3:0]   d_sink = 4'd0;
    logic         d_denied = 1'b0, d_corrupt = 1'b0;
    logic [63:0]  d_data = '0;
    logic         e_valid, e_ready = 1'b0;
    logic [3:0]   e_sink;
    logic         line_we;
    logic [4:0]   line_index;
    logic [52:0]  line_tag;
    logic [1:0]   line_perm;
    logic [511:0] line_data;

    always #5 clk = ~clk;

    rv64g_l1_refill_engine dut (
        .clk_i(clk), .rst_ni(rst_n),
        .refill_req_i(refill_req), .refill_addr_i(refill_addr),
        .refill_done_o(refill_done), .refill_err_o(refill_err), .busy_o(busy),
        .a_valid_o(a_valid), .a_ready_i(a_ready), .a_opcode_o(a_opcode), .a_param_o(a_param),
        .a_size_o(a_size), .a_source_o(a_source), .a_address_o(a_address),
        .d_valid_i(d_valid), .d_ready_o(d_ready), .d_opcode_i(d_opcode), .d_param_i(d_param),
        .d_sink_i(d_sink), .d_denied_i(d_denied), .d_corrupt_i(d_corrupt), .d_data_i(d_data),
        .e_valid_o(e_valid), .e_ready_i(e_ready), .e_sink_o(e_sink),
        .line_we_o(line_we), .line_index_o(line_index), .line_tag_o(line_tag),
        .line_perm_o(line_perm), .line_data_o(line_data)
    );

    typedef struct {
        logic [4:0]   index;
        logic [52:0]  tag;
        logic [511:0] data;
        logic [1:0]   perm;
    } wr_t;

    wr_t         wq[$];
    bit          dq[$];
    logic [63:0] beat_data [BEATS];
    int checks = 0, errors = 0;
    int acq_cnt = 0, ack_cnt = 0, we_cnt = 0, done_cnt = 0;
    int exp_we = 0, exp_done = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [152:0] ctrl_outs();
        return {refill_done, refill_err, busy, a_valid, a_opcode, a_param, a_size, a_source,
                a_address, d_ready, e_valid, e_sink, line_we, line_index, line_tag, line_perm};
    endfunction

    task automatic set_beats(input bit incr);
        for (int k = 0; k < BEATS; k++)
            beat_data[k] = incr ? 64'(8'h11 * (k + 1)) : {$urandom(), $urandom()};
    endtask

    // Reference model of the array write: index = addr[10:6], tag = addr[63:11].
    task automatic push_write(input logic [63:0] addr, input logic [1:0] prm);
        wr_t w;
        logic [63:0] sh_i, sh_t;
        sh_i = addr >> 6;
        sh_t = addr >> 11;
        w.index = sh_i[4:0];
        w.tag   = sh_t[52:0];
        for (int k = 0; k < BEATS; k++) w.data[k*64 +: 64] = beat_data[k];
        w.perm  = (prm == 2'd0) ? 2'b10 : 2'b01;
        wq.push_back(w);
        exp_we++;
    endtask

    task automatic push_done(input bit err);
        dq.push_back(err);
        exp_done++;
    endtask

    task automatic refill(input logic [63:0] addr, input logic [1:0] prm, input logic [3:0] snk,
                          input int deny_beat, input int denied_grants, input int corrupt_beat,
                          input bit grant_only, input int a_wait, input bit d_gaps, input int e_wait,
                          input bit busy_req, input bit req_on_done, input int abort_beat,
                          input int exp_lat);
        int cyc = 0, k = 0, aw = 0, ew = 0, grant = 0;
        bit gap_done = 0, fin = 0, busy_req_sent = 0;
        logic [63:0] line_addr;
        wr_t w;
        bit want_err;
        line_addr = addr & ~64'h3F;
        @(negedge clk);
        refill_req  = 1'b1;
        refill_addr = addr;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            refill_req = 1'b0;
            if (cyc == 1) chk("busy_after_accept", busy, 1'b1);
            // A channel: fields must sit still for the whole valid period.
            a_ready = 1'b0;
            if (a_valid) begin
                chk("a_opcode", a_opcode, 3'd6);
                chk("a_param", a_param, 3'd0);
                chk("a_size", a_size, 4'd6);
                chk("a_source", a_source, 4'd0);
                chk("a_address", a_address, line_addr);
                a_ready = (aw >= a_wait);
                aw++;
                if (a_ready) begin acq_cnt++; aw = 0; k = 0; end
            end
            // D channel
            d_valid = 1'b0;
            if (d_ready) begin
                if (abort_beat >= 0 && k == abort_beat) begin
                    rst_n = 1'b0;
                    #1;
                    chk("reset_ctrl_outs", ctrl_outs(), '0);
                    chk("reset_line_data", line_data, '0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    fin = 1;
                    break;
                end
                if (d_gaps && (k % 2 == 1) && !gap_done) begin
                    gap_done = 1;
                end else begin
                    gap_done  = 0;
                    d_valid   = 1'b1;
                    d_data    = beat_data[k];
                    d_sink    = (k == 0) ? snk : snk + 4'(k);
                    d_param   = (k == 0) ? prm : prm ^ 2'd1;
                    d_opcode  = grant_only ? 3'd4 : 3'd5;
                    d_denied  = (grant < denied_grants) && (k == deny_beat);
                    d_corrupt = (k == corrupt_beat);
                    k++;
                    if (k == BEATS || grant_only) grant++;
                end
            end
            if (busy_req && !busy_req_sent && k == 3) begin
                refill_req  = 1'b1;
                refill_addr = addr ^ 64'h0000_0000_0001_0FC0;
                busy_req_sent = 1;
            end
            // E channel
            e_ready = 1'b0;
            if (e_valid) begin
                chk("e_sink", e_sink, snk);
                e_ready = (ew >= e_wait);
                ew++;
                if (e_ready) begin ack_cnt++; ew = 0; end
            end
            if (line_we) begin
                we_cnt++;
                chk("line_we_expected", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("line_index", line_index, w.index);
                    chk("line_tag", line_tag, w.tag);
                    chk("line_data", line_data, w.data);
                    chk("line_perm", line_perm, w.perm);
                end
            end
            if (refill_done) begin
                done_cnt++;
                chk("busy_at_done", busy, 1'b1);
                chk("done_expected", int'(dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    want_err = dq.pop_front();
                    chk("refill_err", refill_err, want_err);
                end
                // The request cycle counts as cycle 1 of the refill.
                if (exp_lat > 0) chk("latency", cyc + 1, exp_lat);
                $display("refill addr=%h err=%0d cycles=%0d acquires=%0d acks=%0d",
                         addr, refill_err, cyc + 1, acq_cnt, ack_cnt);
                if (req_on_done) begin
                    refill_req  = 1'b1;
                    refill_addr = addr + 64'h4000;
                end
                fin = 1;
            end
        end
        chk("refill_finished", fin, 1'b1);
        @(negedge clk);
        refill_req = 1'b0; d_valid = 1'b0; a_ready = 1'b0; e_ready = 1'b0;
        d_denied = 1'b0; d_corrupt = 1'b0; d_opcode = 3'd5;
        chk("idle_after", {busy, a_valid, refill_done, line_we}, 4'b0000);
        @(negedge clk);
        chk("no_restart", {busy, a_valid}, 2'b00);
    endtask

    initial begin
        int acq0, ack0;
        #2;
        chk("reset_ctrl_outs", ctrl_outs(), '0);
        chk("reset_line_data", line_data, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic refill, zero-wait channels.
        set_beats(1);
        push_write(64'h1010, 2'd0);
        push_done(0);
        refill(64'h1010, 2'd0, 4'd3, -1, 0, -1, 0, 0, 0, 0, 0, 0, -1, 13);

        // Backpressure on A, D and E.
        set_beats(0);
        push_write(64'h0000_7A5C_3F87, 2'd0);
        push_done(0);
        refill(64'h0000_7A5C_3F87, 2'd0, 4'd9, -1, 0, -1, 0, 4, 1, 2, 0, 0, -1, 23);

        // Grant to Branch.
        set_beats(0);
        push_write(64'hFFFF_0000_1234_56C8, 2'd1);
        push_done(0);
        refill(64'hFFFF_0000_1234_56C8, 2'd1, 4'd5, -1, 0, -1, 0, 0, 0, 0, 0, 0, -1, 13);

        // Denied on beat 3.
        set_beats(0);
        acq0 = acq_cnt; ack0 = ack_cnt;
`ifdef REFILL_DENIED_RETRY_EN
        push_write(64'h2040, 2'd0);
        push_done(0);
        refill(64'h2040, 2'd0, 4'd7, 3, 1, -1, 0, 0, 0, 0, 0, 0, -1, 0);
        chk("denied_retry_acquires", acq_cnt - acq0, 2);
        chk("denied_retry_acks", ack_cnt - ack0, 2);
        acq0 = acq_cnt; ack0 = ack_cnt;
        push_done(1);
        refill(64'h2080, 2'd0, 4'd7, 3, 99, -1, 0, 0, 0, 0, 0, 0, -1, 0);
        chk("denied_final_acquires", acq_cnt - acq0, 4);
`else
        push_done(1);
        refill(64'h2040, 2'd0, 4'd7, 3, 1, -1, 0, 0, 0, 0, 0, 0, -1, 13);
        chk("denied_acquires", acq_cnt - acq0, 1);
        chk("denied_acks", ack_cnt - ack0, 1);
`endif

        // Corrupt beat, then a dataless Grant.
        set_beats(0);
        acq0 = acq_cnt; ack0 = ack_cnt;
        push_done(1);
        refill(64'h3300, 2'd0, 4'd2, -1, 0, 5, 0, 0, 0, 0, 0, 0, -1, 13);
        push_done(1);
        refill(64'h3340, 2'd0, 4'd6, -1, 0, -1, 1, 0, 0, 0, 0, 0, -1, 0);
        chk("error_acks", ack_cnt - ack0, 2);

        // Second request while busy, plus a request on the done cycle.
        set_beats(0);
        push_write(64'h0000_0000_0ABC_DE40, 2'd0);
        push_done(0);
        refill(64'h0000_0000_0ABC_DE40, 2'd0, 4'd1, -1, 0, -1, 0, 0, 0, 0, 1, 1, -1, 13);

        // Reset during BEATS, then a clean refill.
        set_beats(0);
        refill(64'h5580, 2'd0, 4'd4, -1, 0, -1, 0, 0, 0, 0, 0, 0, 4, 0);
        set_beats(1);
        push_write(64'h5580, 2'd0);
        push_done(0);
        refill(64'h5580, 2'd0, 4'd4, -1, 0, -1, 0, 0, 0, 0, 0, 0, -1, 13);

        chk("total_line_we", we_cnt, exp_we);
        chk("total_done", done_cnt, exp_done);
        chk("write_queue_drained", wq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
